// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Run-control FSM placed directly upstream of the CPU clock generator.
// PROCESS_FINISHED=1 holds the generated CPU clock (TICK) stopped. The FSM
// starts, single-steps, aborts and stops execution from host controls and
// the decoder's halt level. Rising edges of TICK are counted into a
// saturating CYCLE_COUNT that is cleared only by reset or an accepted START.
//
// Optional build macro: RUN_WATCHDOG_EN
//   Defined   : while RUN or STEP_PULSE, CYCLE_COUNT == WATCHDOG_LIMIT forces
//               DONE and sets the sticky TIMEOUT flag (cleared by START/reset).
//               A halt in the same cycle wins and TIMEOUT stays 0.
//   Undefined : no watchdog logic, TIMEOUT tied 0, WATCHDOG_LIMIT unused.
//
// Handshake/timing note: every control input is sampled on the rising edge
// of MAIN_CLOCK; every output is a register, so a decision taken on edge N
// is visible just after edge N and the clock generator reacts on edge N+1.
// Event priority per cycle: ABORT > HALT_DETECTED > watchdog > START /
// STEP_REQ / STEP_MODE. STATE_DBG mirrors the FSM state register.

module cpu_run_controller #(
    parameter int          CNT_W          = 16,
    parameter int unsigned WATCHDOG_LIMIT = 32'h0000_FFFF
) (
    input  logic             MAIN_CLOCK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             ABORT,
    input  logic             STEP_MODE,
    input  logic             STEP_REQ,
    input  logic             HALT_DETECTED,
    input  logic             TICK,
    output logic             PROCESS_FINISHED,
    output logic             RUNNING,
    output logic             DONE,
    output logic [CNT_W-1:0] CYCLE_COUNT,
    output logic             TIMEOUT,
    output logic [2:0]       STATE_DBG
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RUN        = 3'd1,
        S_STEP_HOLD  = 3'd2,
        S_STEP_PULSE = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    // A step releases the CPU clock for two MAIN_CLOCK cycles: the generator
    // restarts from TICK=0, so two cycles give one full high/low TICK period.
    localparam logic [1:0] STEP_LEN = 2'd2;

    state_t     state;
    state_t     state_nxt;
    logic       start_go;   // START accepted this cycle (clears count/timeout)
    logic       step_load;  // STEP_REQ accepted this cycle
    logic       wd_hit;     // watchdog limit reached (0 when feature absent)
    logic [1:0] step_cnt;
    logic       tick_d;
    logic       tick_rise;

    assign tick_rise = TICK & ~tick_d;
    assign STATE_DBG = state;

    // Next-state decision with the fixed event priority.
    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        step_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (!ABORT && START) begin
                    start_go  = 1'b1;
                    state_nxt = STEP_MODE ? S_STEP_HOLD : S_RUN;
                end
            end
            S_RUN: begin
                if (ABORT)              state_nxt = S_IDLE;
                else if (HALT_DETECTED) state_nxt = S_DONE;
                else if (wd_hit)        state_nxt = S_DONE;
                else if (STEP_MODE)     state_nxt = S_STEP_HOLD;
            end
            S_STEP_HOLD: begin
                if (ABORT)              state_nxt = S_IDLE;
                else if (HALT_DETECTED) state_nxt = S_DONE;
                else if (!STEP_MODE)    state_nxt = S_RUN;
                else if (STEP_REQ) begin
                    state_nxt = S_STEP_PULSE;
                    step_load = 1'b1;
                end
            end
            S_STEP_PULSE: begin
                // STEP_REQ is deliberately not looked at here: not queued.
                if (ABORT)                   state_nxt = S_IDLE;
                else if (HALT_DETECTED)      state_nxt = S_DONE;
                else if (wd_hit)             state_nxt = S_DONE;
                else if (step_cnt == 2'd1)   state_nxt = S_STEP_HOLD;
            end
            S_DONE: begin
                if (ABORT) state_nxt = S_IDLE;
                else if (START) begin
                    start_go  = 1'b1;
                    state_nxt = STEP_MODE ? S_STEP_HOLD : S_RUN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and registered status outputs derived from the next state.
    always_ff @(posedge MAIN_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state            <= S_IDLE;
            PROCESS_FINISHED <= 1'b1;
            RUNNING          <= 1'b0;
            DONE             <= 1'b0;
            step_cnt         <= 2'd0;
        end else begin
            state            <= state_nxt;
            PROCESS_FINISHED <= !((state_nxt == S_RUN) || (state_nxt == S_STEP_PULSE));
            RUNNING          <= (state_nxt == S_RUN) || (state_nxt == S_STEP_PULSE);
            DONE             <= (state_nxt == S_DONE);
            if (step_load)
                step_cnt <= STEP_LEN;
            else if ((state == S_STEP_PULSE) && (step_cnt != 2'd0))
                step_cnt <= step_cnt - 2'd1;
        end
    end

    // TICK edge detector and saturating CPU cycle counter (counts in every state).
    always_ff @(posedge MAIN_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            tick_d      <= 1'b0;
            CYCLE_COUNT <= '0;
        end else begin
            tick_d <= TICK;
            if (start_go)
                CYCLE_COUNT <= '0;
            else if (tick_rise && (CYCLE_COUNT != {CNT_W{1'b1}}))
                CYCLE_COUNT <= CYCLE_COUNT + 1'b1;
        end
    end

`ifdef RUN_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(WATCHDOG_LIMIT);

    logic timeout_q;

    assign wd_hit  = (CYCLE_COUNT == WD_LIMIT);
    assign TIMEOUT = timeout_q;

    // Sticky timeout flag: set when the watchdog actually ends a run.
    always_ff @(posedge MAIN_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            timeout_q <= 1'b0;
        end else if (start_go) begin
            timeout_q <= 1'b0;
        end else if (((state == S_RUN) || (state == S_STEP_PULSE)) &&
                     !ABORT && !HALT_DETECTED && wd_hit) begin
            timeout_q <= 1'b1;
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// Testbench for cpu_run_controller. Two instances share every input: a
// 16-bit counter build and a 4-bit counter build (watchdog limit 8) so that
// saturation and the watchdog can be observed side by side. A behavioural
// reference model, advanced on each rising edge, predicts all outputs.

module tb_cpu_run_controller;

    logic MAIN_CLOCK    = 1'b0;
    logic RESET_N       = 1'b0;
    logic START         = 1'b0;
    logic ABORT         = 1'b0;
    logic STEP_MODE     = 1'b0;
    logic STEP_REQ      = 1'b0;
    logic HALT_DETECTED = 1'b0;
    logic TICK          = 1'b0;

    logic        pf16, run16, done16, to16;
    logic [15:0] cnt16;
    logic [2:0]  st16;
    logic        pf4, run4, done4, to4;
    logic [3:0]  cnt4;
    logic [2:0]  st4;

    int tests_run    = 0;
    int tests_failed = 0;

    cpu_run_controller #(.CNT_W(16)) dut16 (
        .MAIN_CLOCK(MAIN_CLOCK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
        .STEP_MODE(STEP_MODE), .STEP_REQ(STEP_REQ), .HALT_DETECTED(HALT_DETECTED),
        .TICK(TICK), .PROCESS_FINISHED(pf16), .RUNNING(run16), .DONE(done16),
        .CYCLE_COUNT(cnt16), .TIMEOUT(to16), .STATE_DBG(st16)
    );

    cpu_run_controller #(.CNT_W(4), .WATCHDOG_LIMIT(8)) dut4 (
        .MAIN_CLOCK(MAIN_CLOCK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
        .STEP_MODE(STEP_MODE), .STEP_REQ(STEP_REQ), .HALT_DETECTED(HALT_DETECTED),
        .TICK(TICK), .PROCESS_FINISHED(pf4), .RUNNING(run4), .DONE(done4),
        .CYCLE_COUNT(cnt4), .TIMEOUT(to4), .STATE_DBG(st4)
    );

    // ---------------- clock ----------------
    always #5 MAIN_CLOCK = ~MAIN_CLOCK;

    // ---------------- reference model ----------------
    // Modes: 0 idle, 1 free run, 2 step hold, 3 step release, 4 done.
    int m_mode[2];
    int m_cnt[2];
    int m_left[2];
    bit m_td[2];
    bit m_to[2];
    int m_max[2] = '{65535, 15};
    int m_lim[2] = '{65535, 8};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_cnt[i] = 0; m_left[i] = 0; m_td[i] = 0; m_to[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit rise;
            bit wd;
            bit go;
            rise = TICK && !m_td[i];
            wd   = 1'b0;
            go   = 1'b0;
`ifdef RUN_WATCHDOG_EN
            wd = (m_cnt[i] == m_lim[i]);
`endif
            if (m_mode[i] == 0 || m_mode[i] == 4) begin
                if (ABORT) m_mode[i] = 0;
                else if (START) begin
                    go = 1'b1;
                    m_mode[i] = STEP_MODE ? 2 : 1;
                end
            end else if (ABORT) begin
                m_mode[i] = 0;
            end else if (HALT_DETECTED) begin
                m_mode[i] = 4;
            end else if (m_mode[i] == 2) begin
                if (!STEP_MODE) m_mode[i] = 1;
                else if (STEP_REQ) begin
                    m_mode[i] = 3;
                    m_left[i] = 2;
                end
            end else if (wd) begin
                m_mode[i] = 4;
                m_to[i]   = 1'b1;
            end else if (m_mode[i] == 1) begin
                if (STEP_MODE) m_mode[i] = 2;
            end else begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) m_mode[i] = 2;
            end
            if (go) begin
                m_cnt[i] = 0;
                m_to[i]  = 1'b0;
            end else if (rise && m_cnt[i] < m_max[i]) begin
                m_cnt[i] = m_cnt[i] + 1;
            end
            m_td[i] = TICK;
        end
    endtask

    function automatic bit exp_run(int i);
        return (m_mode[i] == 1) || (m_mode[i] == 3);
    endfunction

    // Packed {PF, RUNNING, DONE, TIMEOUT, CYCLE_COUNT[15:0]} views.
    function automatic logic [19:0] exp_vec(int i);
        logic [15:0] c;
        c = 16'(m_cnt[i]);
        return {!exp_run(i), exp_run(i), (m_mode[i] == 4), m_to[i], c};
    endfunction

    function automatic logic [19:0] obs_vec(int i);
        if (i == 0) return {pf16, run16, done16, to16, cnt16};
        return {pf4, run4, done4, to4, 12'd0, cnt4};
    endfunction

    // ---------------- driver ----------------
    task automatic cycle();
        @(posedge MAIN_CLOCK);
        model_edge();
        @(negedge MAIN_CLOCK);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [19:0] rst_vec;
        rst_vec = {1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        RESET_N = 1'b0;
        model_reset();
        repeat (2) @(negedge MAIN_CLOCK);
        RESET_N = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (obs_vec(i) !== rst_vec) begin
                tests_failed++;
                $display("FAIL reset_state inst=%0d got=%h exp=%h", i, obs_vec(i), rst_vec);
            end
        end
        for (int k = 0; k < 5; k++) begin
            TICK = 1'b1; cycle();
            TICK = 1'b0; cycle();
            tests_run++;
            if (obs_vec(0) !== exp_vec(0)) begin
                tests_failed++;
                $display("FAIL idle_tick k=%0d got=%h exp=%h", k, obs_vec(0), exp_vec(0));
            end
        end
        tests_run++;
        if (cnt16 !== 16'd5 || pf16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_tick_count got cnt=%0d pf=%b exp cnt=5 pf=1", cnt16, pf16);
        end
    endtask

    task automatic test_free_run();
        STEP_MODE = 1'b0; TICK = 1'b0;
        START = 1'b1; cycle(); START = 1'b0;
        tests_run++;
        if (pf16 !== 1'b0 || run16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL free_run_start got pf=%b run=%b exp pf=0 run=1", pf16, run16);
        end
        for (int k = 0; k < 20; k++) begin
            TICK = ~TICK; cycle();
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    tests_failed++;
                    $display("FAIL free_run k=%0d inst=%0d got=%h exp=%h", k, i, obs_vec(i), exp_vec(i));
                end
            end
        end
        HALT_DETECTED = 1'b1; cycle(); HALT_DETECTED = 1'b0;
        tests_run++;
        if (done16 !== 1'b1 || pf16 !== 1'b1 || run16 !== 1'b0 || cnt16 !== 16'd10) begin
            tests_failed++;
            $display("FAIL free_run_halt got done=%b pf=%b run=%b cnt=%0d exp 1 1 0 10",
                     done16, pf16, run16, cnt16);
        end
    endtask

    task automatic test_step();
        int low;
        STEP_MODE = 1'b1; TICK = 1'b0;
        START = 1'b1; cycle(); START = 1'b0;
        tests_run++;
        if (pf16 !== 1'b1 || run16 !== 1'b0 || cnt16 !== 16'd0) begin
            tests_failed++;
            $display("FAIL step_hold got pf=%b run=%b cnt=%0d exp 1 0 0", pf16, run16, cnt16);
        end
        for (int p = 0; p < 3; p++) begin
            low = 0;
            for (int j = 0; j < 5; j++) begin
                STEP_REQ = (j < 2);  // second request lands inside the pulse
                TICK = exp_run(0) ? ~TICK : 1'b0;
                cycle();
                if (pf16 === 1'b0) low++;
                tests_run++;
                if (obs_vec(0) !== exp_vec(0)) begin
                    tests_failed++;
                    $display("FAIL step p=%0d j=%0d got=%h exp=%h", p, j, obs_vec(0), exp_vec(0));
                end
            end
            tests_run++;
            if (low != 2) begin
                tests_failed++;
                $display("FAIL step_pulse_len p=%0d got=%0d exp=2", p, low);
            end
        end
        STEP_REQ = 1'b0;
        tests_run++;
        if (cnt16 !== 16'd3) begin
            tests_failed++;
            $display("FAIL step_count got=%0d exp=3", cnt16);
        end
    endtask

    task automatic test_abort();
        STEP_MODE = 1'b0; TICK = 1'b0;
        ABORT = 1'b1; cycle(); ABORT = 1'b0;
        ABORT = 1'b1; START = 1'b1; cycle(); ABORT = 1'b0; START = 1'b0;
        tests_run++;
        if (pf16 !== 1'b1 || run16 !== 1'b0 || done16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_start_idle got pf=%b run=%b done=%b exp 1 0 0", pf16, run16, done16);
        end
        START = 1'b1; cycle(); START = 1'b0;
        repeat (3) cycle();
        tests_run++;
        if (run16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_pre_run got run=%b exp=1", run16);
        end
        ABORT = 1'b1; cycle(); ABORT = 1'b0;
        tests_run++;
        if (pf16 !== 1'b1 || run16 !== 1'b0 || done16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_run got pf=%b run=%b done=%b exp 1 0 0", pf16, run16, done16);
        end
    endtask

    task automatic test_saturation();
        STEP_MODE = 1'b0; TICK = 1'b0;
        START = 1'b1; cycle(); START = 1'b0;
        for (int k = 0; k < 80; k++) begin
            TICK = ~TICK; cycle();
            tests_run++;
            if (obs_vec(1) !== exp_vec(1)) begin
                tests_failed++;
                $display("FAIL sat k=%0d inst=1 got=%h exp=%h", k, obs_vec(1), exp_vec(1));
            end
        end
        tests_run++;
        if (cnt4 !== 4'd15 || cnt16 !== 16'd40) begin
            tests_failed++;
            $display("FAIL sat_count got cnt4=%0d cnt16=%0d exp 15 40", cnt4, cnt16);
        end
`ifdef RUN_WATCHDOG_EN
        tests_run++;
        if (to4 !== 1'b1 || done4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL watchdog got to=%b done=%b exp 1 1", to4, done4);
        end
`endif
        HALT_DETECTED = 1'b1; cycle(); HALT_DETECTED = 1'b0;
        START = 1'b1; cycle(); START = 1'b0;
        tests_run++;
        if (to4 !== 1'b0 || cnt4 !== 4'd0 || cnt16 !== 16'd0) begin
            tests_failed++;
            $display("FAIL restart_clear got to4=%b cnt4=%0d cnt16=%0d exp 0 0 0", to4, cnt4, cnt16);
        end
        ABORT = 1'b1; cycle(); ABORT = 1'b0;
    endtask

    task automatic test_back_to_back();
        STEP_MODE = 1'b0; TICK = 1'b0;
        HALT_DETECTED = 1'b1;
        for (int k = 0; k < 3; k++) begin
            START = 1'b1; cycle(); START = 1'b0;
            tests_run++;
            if (run16 !== 1'b1 || done16 !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_run k=%0d got run=%b done=%b exp 1 0", k, run16, done16);
            end
            cycle();
            tests_run++;
            if (done16 !== 1'b1 || pf16 !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_done k=%0d got done=%b pf=%b exp 1 1", k, done16, pf16);
            end
        end
        HALT_DETECTED = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            START         = ($urandom_range(0, 7) == 0);
            ABORT         = ($urandom_range(0, 31) == 0);
            STEP_REQ      = ($urandom_range(0, 3) == 0);
            HALT_DETECTED = ($urandom_range(0, 19) == 0);
            TICK          = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) STEP_MODE = ~STEP_MODE;
            cycle();
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    tests_failed++;
                    $display("FAIL random k=%0d inst=%0d got=%h exp=%h", k, i, obs_vec(i), exp_vec(i));
                end
            end
        end
        START = 1'b0; ABORT = 1'b0; STEP_REQ = 1'b0; HALT_DETECTED = 1'b0;
    endtask

    task automatic test_reset_midrun();
        STEP_MODE = 1'b0; TICK = 1'b0;
        ABORT = 1'b1; cycle(); ABORT = 1'b0;
        START = 1'b1; cycle(); START = 1'b0;
        for (int k = 0; k < 6; k++) begin
            TICK = ~TICK; cycle();
        end
        #2 RESET_N = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (obs_vec(i) !== exp_vec(i)) begin
                tests_failed++;
                $display("FAIL reset_midrun inst=%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
            end
        end
        @(negedge MAIN_CLOCK);
        RESET_N = 1'b1;
        TICK = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_step();
        test_abort();
        test_saturation();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
